vn2_inject: RTL and testbench

Upstream counterpart of the VN2 ejection stage. It accepts complete VN2 messages from up to three local tile sources (L2, MC, NCA), picks one with a round-robin arbiter, and serializes it into 64-bit flits on the VN2 injection port of the router. The flit layout and type sequence are exactly what the VN2 ejection stage reassembles.

---
 rtl/vn2_inject_pkg.sv | 29 ++
 rtl/vn_rr_arb3.sv | 41 ++++
 rtl/vn2_inject.sv | 186 ++++++++++++++++++
 tb/tb_vn2_inject.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vn2_inject_pkg.sv
// Shared encodings for the VN2 injection path: flit types, length codes and serializer states.
// The flit-type and length encodings must match the VN2 ejection stage exactly.
package vn2_inject_pkg;

    localparam int unsigned VN2_MSG_W = 576;
    localparam int unsigned FLIT_W    = 64;
    localparam int unsigned NUM_SRC   = 3;

    typedef enum logic [1:0] {
        FtHeader     = 2'd0,
        FtPayload    = 2'd1,
        FtTail       = 2'd2,
        FtHeaderTail = 2'd3
    } flit_type_e;

    // Length codes: number of flits in the message.
    localparam logic [1:0] Len1   = 2'd0;
    localparam logic [1:0] Len2   = 2'd1;
    localparam logic [1:0] Len9   = 2'd2;
    localparam logic [1:0] LenBad = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHead = 2'd1,
        StBody = 2'd2,
        StTail = 2'd3
    } ser_state_e;

endpackage

// File: rtl/vn_rr_arb3.sv
// Three-requester round-robin arbiter with enable and one-hot grant.
// The pointer moves to the requester after the winner whenever a grant is issued.
module vn_rr_arb3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [2:0] gnt
);

    logic [1:0] ptr_q, ptr_d;

    always_comb begin
        gnt = 3'b000;
        case (ptr_q)
            2'd1:    gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            2'd2:    gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default: gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
        if (!en) begin
            gnt = 3'b000;
        end

        ptr_d = ptr_q;
        case (gnt)
            3'b001:  ptr_d = 2'd1;
            3'b010:  ptr_d = 2'd2;
            3'b100:  ptr_d = 2'd0;
            default: ptr_d = ptr_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vn2_inject.sv
// VN2 injection stage: latches whole messages from L2/MC/NCA, arbitrates round-robin and
// serializes the winner into 64-bit flits for the router's VN2 injection port.
module vn2_inject
    import vn2_inject_pkg::*;
#(
    parameter int ID        = 0,
    parameter int VNID      = 2,
    parameter int FLIT_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_fL2,
    input  logic                 req_fMC,
    input  logic                 req_fNCA,
    input  logic [VN2_MSG_W-1:0] msg_fL2,
    input  logic [VN2_MSG_W-1:0] msg_fMC,
    input  logic [VN2_MSG_W-1:0] msg_fNCA,
    input  logic [1:0]           len_fL2,
    input  logic [1:0]           len_fMC,
    input  logic [1:0]           len_fNCA,
    output logic                 avail_toL2,
    output logic                 avail_toMC,
    output logic                 avail_toNCA,
    input  logic                 go,
    output logic                 valid,
    output logic [FLIT_W-1:0]    flit,
    output logic [1:0]           flit_type,
    output logic [31:0]          flits_sent
);

    if (FLIT_SIZE != 64 || ID < 0 || VNID < 0) begin : g_bad_param
        $error("vn2_inject supports only FLIT_SIZE = 64 with non-negative ID/VNID");
    end

    logic [2:0]           req_in;
    logic [VN2_MSG_W-1:0] msg_in [NUM_SRC];
    logic [1:0]           len_in [NUM_SRC];

    assign req_in    = {req_fNCA, req_fMC, req_fL2};
    assign msg_in[0] = msg_fL2;
    assign msg_in[1] = msg_fMC;
    assign msg_in[2] = msg_fNCA;
    assign len_in[0] = len_fL2;
    assign len_in[1] = len_fMC;
    assign len_in[2] = len_fNCA;

    logic [2:0]           pend_q, pend_d;
    logic [VN2_MSG_W-1:0] lmsg_q [NUM_SRC];
    logic [VN2_MSG_W-1:0] lmsg_d [NUM_SRC];
    logic [1:0]           llen_q [NUM_SRC];
    logic [1:0]           llen_d [NUM_SRC];

    ser_state_e           state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [VN2_MSG_W-1:0] msg_q, msg_d;
    logic [1:0]           len_q, len_d;
    logic [31:0]          cnt_q, cnt_d;

    logic [2:0]           req_ok;
    logic [2:0]           arb_req;
    logic [2:0]           gnt;
    logic                 xfer;
    logic                 last_xfer;
    logic                 free;
    logic [VN2_MSG_W-1:0] sel_msg;
    logic [1:0]           sel_len;

    // Illegal lengths and strobes onto a full latch are dropped without touching state.
    assign req_ok    = req_in & ~pend_q &
                       {len_fNCA != LenBad, len_fMC != LenBad, len_fL2 != LenBad};
    assign valid     = (state_q != StIdle);
    assign xfer      = valid & go;
    assign last_xfer = xfer & (((state_q == StHead) && (len_q == Len1)) || (state_q == StTail));
    assign free      = (state_q == StIdle) | last_xfer;
    // Fresh strobes compete alongside latched ones so an idle serializer takes them directly.
    assign arb_req   = pend_q | req_ok;

    vn_rr_arb3 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (free),
        .req (arb_req),
        .gnt (gnt)
    );

    always_comb begin
        pend_d  = pend_q;
        lmsg_d  = lmsg_q;
        llen_d  = llen_q;
        sel_msg = '0;
        sel_len = Len1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_ok[i] && !gnt[i]) begin
                pend_d[i] = 1'b1;
                lmsg_d[i] = msg_in[i];
                llen_d[i] = len_in[i];
            end
            if (gnt[i]) begin
                pend_d[i] = 1'b0;
                sel_msg   = pend_q[i] ? lmsg_q[i] : msg_in[i];
                sel_len   = pend_q[i] ? llen_q[i] : len_in[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        msg_d   = msg_q;
        len_d   = len_q;
        cnt_d   = cnt_q + {31'd0, xfer};
        case (state_q)
            StHead: begin
                if (xfer) begin
                    idx_d = 4'd1;
                    if (len_q == Len1) begin
                        state_d = StIdle;
                    end else if (len_q == Len2) begin
                        state_d = StTail;
                    end else begin
                        state_d = StBody;
                    end
                end
            end
            StBody: begin
                if (xfer) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd7) begin
                        state_d = StTail;
                    end
                end
            end
            StTail: begin
                if (xfer) begin
                    state_d = StIdle;
                end
            end
            default: ;
        endcase
        // A grant only happens when free, so it overrides the final-flit return to idle.
        if (|gnt) begin
            state_d = StHead;
            idx_d   = 4'd0;
            msg_d   = sel_msg;
            len_d   = sel_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 3'b000;
            lmsg_q  <= '{default: '0};
            llen_q  <= '{default: '0};
            state_q <= StIdle;
            idx_q   <= 4'd0;
            msg_q   <= '0;
            len_q   <= Len1;
            cnt_q   <= 32'd0;
        end else begin
            pend_q  <= pend_d;
            lmsg_q  <= lmsg_d;
            llen_q  <= llen_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            msg_q   <= msg_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        flit      = msg_q[{idx_q, 6'd0} +: FLIT_W];
        flit_type = FtTail;
        case (state_q)
            StHead:  flit_type = (len_q == Len1) ? FtHeaderTail : FtHeader;
            StBody:  flit_type = FtPayload;
            default: flit_type = FtTail;
        endcase
    end

    assign avail_toL2  = ~pend_q[0];
    assign avail_toMC  = ~pend_q[1];
    assign avail_toNCA = ~pend_q[2];
    assign flits_sent  = cnt_q;

endmodule

// File: tb/tb_vn2_inject.sv
// Scoreboard bench for vn2_inject: stimulus pushes expected flits, a negedge monitor pops
// and compares every flit the DUT presents.
module tb_vn2_inject;
    import vn2_inject_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_fL2 = 1'b0, req_fMC = 1'b0, req_fNCA = 1'b0;
    logic [575:0] msg_fL2 = '0, msg_fMC = '0, msg_fNCA = '0;
    logic [1:0]   len_fL2 = '0, len_fMC = '0, len_fNCA = '0;
    logic         avail_toL2, avail_toMC, avail_toNCA;
    logic         go = 1'b1;
    logic         valid;
    logic [63:0]  flit;
    logic [1:0]   flit_type;
    logic [31:0]  flits_sent;

    typedef struct packed {
        logic [63:0] f;
        logic [1:0]  t;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    vn2_inject #(.ID(0), .VNID(2), .FLIT_SIZE(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_fL2     (req_fL2),
        .req_fMC     (req_fMC),
        .req_fNCA    (req_fNCA),
        .msg_fL2     (msg_fL2),
        .msg_fMC     (msg_fMC),
        .msg_fNCA    (msg_fNCA),
        .len_fL2     (len_fL2),
        .len_fMC     (len_fMC),
        .len_fNCA    (len_fNCA),
        .avail_toL2  (avail_toL2),
        .avail_toMC  (avail_toMC),
        .avail_toNCA (avail_toNCA),
        .go          (go),
        .valid       (valid),
        .flit        (flit),
        .flit_type   (flit_type),
        .flits_sent  (flits_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compares the head of the queue whenever a flit is offered; stalled flits are re-checked.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (q.size() == 0) begin
                total++;
                if (go) begin
                    bad++;
                    $display("FAIL unexpected_flit: got %0h type %0d want none", flit, flit_type);
                end
            end else begin
                check("flit", flit, q[0].f);
                check("flit_type", {62'd0, flit_type}, {62'd0, q[0].t});
                if (go) void'(q.pop_front());
            end
        end
    end

    function automatic logic [575:0] mk(input logic [63:0] base);
        logic [575:0] m;
        for (int k = 0; k < 9; k++) m[k*64 +: 64] = base + 64'(k);
        return m;
    endfunction

    task automatic push_msg(input logic [575:0] m, input logic [1:0] l);
        if (l == Len1) begin
            q.push_back('{f: m[63:0], t: FtHeaderTail});
        end else if (l == Len2) begin
            q.push_back('{f: m[63:0], t: FtHeader});
            q.push_back('{f: m[127:64], t: FtTail});
        end else begin
            q.push_back('{f: m[63:0], t: FtHeader});
            for (int k = 1; k < 8; k++) q.push_back('{f: m[k*64 +: 64], t: FtPayload});
            q.push_back('{f: m[575:512], t: FtTail});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int src, input logic [575:0] m, input logic [1:0] l);
        case (src)
            0: begin req_fL2 = 1'b1; msg_fL2 = m; len_fL2 = l; end
            1: begin req_fMC = 1'b1; msg_fMC = m; len_fMC = l; end
            default: begin req_fNCA = 1'b1; msg_fNCA = m; len_fNCA = l; end
        endcase
    endtask

    task automatic fire();
        tick();
        req_fL2 = 1'b0;
        req_fMC = 1'b0;
        req_fNCA = 1'b0;
    endtask

    function automatic logic [63:0] avail3();
        return {61'd0, avail_toNCA, avail_toMC, avail_toL2};
    endfunction

    initial begin
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_avail", avail3(), 64'h7);
        check("rst_cnt", flits_sent, 0);
        check("rst_flit", flit, 0);
        check("rst_type", flit_type, FtTail);
        rst = 1'b0;
        tick();

        // Single-flit message bypasses the latch.
        push_msg(mk(64'hA000), Len1);
        drive(0, mk(64'hA000), Len1);
        fire();
        check("t1_valid", valid, 1);
        check("t1_avail_l2", avail_toL2, 1);
        tick();
        check("t1_valid_low", valid, 0);
        check("t1_cnt", flits_sent, 1);

        // Nine-flit message in nine consecutive cycles.
        push_msg(mk(64'h0), Len9);
        drive(1, mk(64'h0), Len9);
        fire();
        for (int k = 0; k < 9; k++) begin
            check("t2_valid", valid, 1);
            tick();
        end
        check("t2_valid_low", valid, 0);
        check("t2_cnt", flits_sent, 10);

        // Two-flit message stalled for three cycles on the header.
        push_msg(mk(64'hC000), Len2);
        drive(2, mk(64'hC000), Len2);
        fire();
        go = 1'b0;
        tick();
        tick();
        tick();
        check("t3_cnt_stall", flits_sent, 10);
        go = 1'b1;
        tick();
        tick();
        check("t3_valid_low", valid, 0);
        check("t3_cnt", flits_sent, 12);

        // Two simultaneous three-way bursts.
        for (int b = 0; b < 2; b++) begin
            logic [63:0] base;
            base = 64'hD000 + 64'(b) * 64'h1000;
            push_msg(mk(base + 64'h100), Len1);
            push_msg(mk(base + 64'h200), Len1);
            push_msg(mk(base + 64'h300), Len1);
            drive(0, mk(base + 64'h100), Len1);
            drive(1, mk(base + 64'h200), Len1);
            drive(2, mk(base + 64'h300), Len1);
            fire();
            check("t4_valid1", valid, 1);
            check("t4_avail1", avail3(), 64'h1);
            tick();
            check("t4_valid2", valid, 1);
            check("t4_avail2", avail3(), 64'h3);
            tick();
            check("t4_valid3", valid, 1);
            check("t4_avail3", avail3(), 64'h7);
            tick();
            check("t4_valid_low", valid, 0);
            check("t4_cnt", flits_sent, 32'd15 + 32'(b) * 32'd3);
        end

        // Illegal length is dropped.
        drive(0, mk(64'hBAD0), LenBad);
        fire();
        check("t5_valid", valid, 0);
        check("t5_avail", avail3(), 64'h7);
        tick();
        check("t5_cnt", flits_sent, 18);

        // Strobe onto a full latch is ignored.
        go = 1'b0;
        push_msg(mk(64'hE100), Len1);
        drive(0, mk(64'hE100), Len1);
        fire();
        push_msg(mk(64'hE200), Len1);
        drive(1, mk(64'hE200), Len1);
        fire();
        check("t6_avail_mc_a", avail_toMC, 0);
        drive(1, mk(64'hE300), Len1);
        fire();
        check("t6_avail_mc_b", avail_toMC, 0);
        go = 1'b1;
        tick();
        check("t6_avail_mc_c", avail_toMC, 1);
        tick();
        check("t6_valid_low", valid, 0);
        check("t6_cnt", flits_sent, 20);

        // Asynchronous reset in the middle of a nine-flit message.
        push_msg(mk(64'hF000), Len9);
        drive(0, mk(64'hF000), Len9);
        fire();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t7_valid", valid, 0);
        check("t7_avail", avail3(), 64'h7);
        check("t7_cnt", flits_sent, 0);
        check("t7_flit", flit, 0);
        check("t7_type", flit_type, FtTail);
        q.delete();
        tick();
        rst = 1'b0;
        tick();
        push_msg(mk(64'h7700), Len1);
        drive(2, mk(64'h7700), Len1);
        fire();
        check("t7_restart_valid", valid, 1);
        tick();
        check("t7_restart_cnt", flits_sent, 1);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drain", 64'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
